// File: rtl/ag_pkg.sv
// Shared types and constants for the address-generator tile.
package ag_pkg;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } ag_state_e;

  // Scan order encodings for the mode input.
  localparam logic AG_ROW_MAJOR = 1'b0;
  localparam logic AG_COL_MAJOR = 1'b1;

  // Channel index width; a single-channel tile still carries one bit.
  function automatic int ag_ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ag_tile_if.sv
// Address output bus of the tile.
// Handshake: a transfer happens on a rising edge where addr_valid and
// addr_ready are both 1; while addr_valid=1 and addr_ready=0 the master
// holds address and last stable, and addr_ready may toggle freely.
interface ag_tile_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] address;
  logic              addr_valid;
  logic              addr_ready;
  logic              last;

  modport master (output address, output addr_valid, output last, input addr_ready);
  modport slave  (input address, input addr_valid, input last, output addr_ready);
endinterface

// File: rtl/ag_cnt.sv
// Wrap counter with clear and enable; wrap flags the terminal count
// (cnt == max) so callers can build carry chains without feedback loops.
module ag_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  assign wrap = (cnt == max);

  // Next value: clear dominates, otherwise step and wrap to zero at max.
  always_comb begin
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (en) begin
      nxt = wrap ? '0 : cnt + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/ag_tile.sv
// Tile address generator: scans {ch, row, col} in row- or column-major
// order with channel outermost, one address per accepted handshake.
module ag_tile
  import ag_pkg::*;
#(
  parameter  int ROW_BITS = 4,
  parameter  int COL_BITS = 4,
  parameter  int NUM_CH   = 2,
  localparam int CH_BITS  = ag_ch_bits(NUM_CH),
  localparam int ADDR_W   = CH_BITS + ROW_BITS + COL_BITS
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [ROW_BITS-1:0] num_rows_m1,
  input  logic [COL_BITS-1:0] num_cols_m1,
  input  logic [CH_BITS-1:0]  num_ch_m1,
  ag_tile_if.master           bus,
  output logic                busy,
  output logic                done,
  output ag_state_e           state_dbg
);

  ag_state_e state_q, state_nxt;

  logic                mode_q;
  logic [ROW_BITS-1:0] rows_q, rows_eff;
  logic [COL_BITS-1:0] cols_q, cols_eff;
  logic [CH_BITS-1:0]  chm_q, chm_eff, ch_clamped;

  logic latch, hs;
  logic col_en, row_en, ch_en;
  logic col_wrap, row_wrap, ch_wrap;
  logic [COL_BITS-1:0] col_cnt, col_nxt;
  logic [ROW_BITS-1:0] row_cnt, row_nxt;
  logic [CH_BITS-1:0]  ch_cnt, ch_nxt;
  logic [ADDR_W-1:0]   addr_q;

  logic valid_nxt, last_nxt, done_nxt, busy_nxt;
  logic valid_q, last_q, done_q, busy_q;

  // Abort beats both a new start and a same-cycle handshake.
  assign latch = (state_q == AG_IDLE) && start && !abort;
  assign hs    = (state_q == AG_RUN) && valid_q && bus.addr_ready && !abort;

  // Clamp the requested channel count to what the tile implements.
  always_comb begin
    ch_clamped = num_ch_m1;
    if (32'(num_ch_m1) >= NUM_CH) ch_clamped = CH_BITS'(NUM_CH - 1);
  end

  // Config as it will be after this edge; used to precompute last.
  always_comb begin
    rows_eff = latch ? num_rows_m1 : rows_q;
    cols_eff = latch ? num_cols_m1 : cols_q;
    chm_eff  = latch ? ch_clamped  : chm_q;
  end

  // Config is captured only on the accepting cycle in IDLE.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= AG_ROW_MAJOR;
      rows_q <= '0;
      cols_q <= '0;
      chm_q  <= '0;
    end else if (latch) begin
      mode_q <= mode;
      rows_q <= num_rows_m1;
      cols_q <= num_cols_m1;
      chm_q  <= ch_clamped;
    end
  end

  // Carry chain: the fast index steps on every handshake, the slow index
  // on fast-index wrap, the channel on slow-index wrap.
  always_comb begin
    col_en = 1'b0;
    row_en = 1'b0;
    ch_en  = 1'b0;
    if (mode_q == AG_ROW_MAJOR) begin
      col_en = hs;
      row_en = hs & col_wrap;
      ch_en  = row_en & row_wrap;
    end else begin
      row_en = hs;
      col_en = hs & row_wrap;
      ch_en  = col_en & col_wrap;
    end
  end

  ag_cnt #(.W(COL_BITS)) u_col (
    .clk(sys_clk), .rst_n(reset_n), .clr(latch), .en(col_en), .max(cols_q),
    .cnt(col_cnt), .nxt(col_nxt), .wrap(col_wrap)
  );
  ag_cnt #(.W(ROW_BITS)) u_row (
    .clk(sys_clk), .rst_n(reset_n), .clr(latch), .en(row_en), .max(rows_q),
    .cnt(row_cnt), .nxt(row_nxt), .wrap(row_wrap)
  );
  ag_cnt #(.W(CH_BITS)) u_ch (
    .clk(sys_clk), .rst_n(reset_n), .clr(latch), .en(ch_en), .max(chm_q),
    .cnt(ch_cnt), .nxt(ch_nxt), .wrap(ch_wrap)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= AG_IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      AG_IDLE: if (latch) state_nxt = AG_RUN;
      AG_RUN: begin
        if (abort)            state_nxt = AG_IDLE;
        else if (hs && last_q) state_nxt = AG_DONE;
      end
      AG_DONE: state_nxt = AG_IDLE;
      default: state_nxt = AG_IDLE;
    endcase
  end

  // Output values for the next cycle; last looks at the post-edge indices.
  always_comb begin
    valid_nxt = (state_nxt == AG_RUN);
    busy_nxt  = (state_nxt != AG_IDLE);
    done_nxt  = (state_nxt == AG_DONE);
    last_nxt  = valid_nxt && (ch_nxt == chm_eff) && (row_nxt == rows_eff) &&
                (col_nxt == cols_eff);
  end

  // Output register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign addr_q         = {ch_cnt, row_cnt, col_cnt};
  assign bus.address    = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.last       = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_ag_tile.sv
// Directed bench for ag_tile with a scoreboard of expected {last, address}.
module tb_ag_tile;
  import ag_pkg::*;

  localparam int ADDR_W = 9;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] num_rows_m1 = '0;
  logic [3:0] num_cols_m1 = '0;
  logic [0:0] num_ch_m1 = '0;
  logic       busy, done;
  ag_state_e  state_dbg;

  ag_tile_if #(.ADDR_W(ADDR_W)) bus ();

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] exp_v;

  // Clock and DUT.
  always #5 sys_clk = ~sys_clk;

  ag_tile #(.ROW_BITS(4), .COL_BITS(4), .NUM_CH(2)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .abort(abort),
    .mode(mode), .num_rows_m1(num_rows_m1), .num_cols_m1(num_cols_m1),
    .num_ch_m1(num_ch_m1), .bus(bus), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected scan built from plain nested loops; bit ADDR_W carries last.
  task automatic push_scan(input logic m, input int r, input int c, input int chn);
    int rr, cc, n, total;
    n = 0;
    total = (chn + 1) * (r + 1) * (c + 1);
    for (int k = 0; k <= chn; k++)
      for (int o = 0; o <= (m ? c : r); o++)
        for (int i = 0; i <= (m ? r : c); i++) begin
          rr = m ? i : o;
          cc = m ? o : i;
          n++;
          exp_q.push_back(10'(((n == total) ? 512 : 0) + k * 256 + rr * 16 + cc));
        end
  endtask

  // Scoreboard: every accepted address is popped and compared.
  always @(negedge sys_clk) begin
    if (done) done_cnt++;
    if (bus.addr_valid && bus.addr_ready) begin
      hs_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_hs: observed %0h expected no transfer", {bus.last, bus.address});
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        assert ({bus.last, bus.address} === exp_v) else begin
          errors++;
          $error("FAIL scan_addr: observed %0h expected %0h", {bus.last, bus.address}, exp_v);
        end
      end
    end
  end

  // Wait (bounded) for the done pulse, counting negedges including it.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Full scan with addr_ready held high; config is scrambled mid-scan.
  task automatic run_scan(input logic m, input int r, input int c, input int chr,
                          input string tag);
    int chc, len, cyc, hs0;
    chc = (chr > 1) ? 1 : chr;
    len = (chc + 1) * (r + 1) * (c + 1);
    push_scan(m, r, c, chc);
    mode = m;
    num_rows_m1 = r[3:0];
    num_cols_m1 = c[3:0];
    num_ch_m1 = chr[0:0];
    bus.addr_ready = 1'b1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    hs0 = hs_cnt;
    mode = ~m;
    num_rows_m1 = 4'($urandom_range(0, 15));
    num_cols_m1 = 4'($urandom_range(0, 15));
    wait_done(cyc);
    chk({tag, "_cycles"}, 32'(cyc), 32'(len + 1));
    chk({tag, "_hs"}, 32'(hs_cnt - hs0), 32'(len));
    chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    @(negedge sys_clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int cyc, hs0, d0;
    bus.addr_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_addr", 32'(bus.address), 32'd0);
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(AG_IDLE));
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // Row-major, column-major, single address, channel scan with clamp.
    run_scan(1'b0, 1, 2, 0, "row_major");
    run_scan(1'b1, 1, 2, 0, "col_major");
    run_scan(1'b0, 0, 0, 0, "single");
    run_scan(1'b0, 0, 0, 1, "chan");
    run_scan(1'b1, 0, 0, 3, "chan_clamp");
    run_scan(1'b1, 2, 1, 1, "mixed");

    // Stall on the second address for three cycles.
    push_scan(1'b0, 1, 2, 0);
    mode = 1'b0; num_rows_m1 = 4'd1; num_cols_m1 = 4'd2; num_ch_m1 = 1'b0;
    bus.addr_ready = 1'b1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    hs0 = hs_cnt;
    @(posedge sys_clk); #1;
    bus.addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("stall_addr", 32'(bus.address), 32'h01);
      chk("stall_valid", 32'(bus.addr_valid), 32'd1);
      @(posedge sys_clk); #1;
    end
    bus.addr_ready = 1'b1;
    wait_done(cyc);
    chk("stall_cycles", 32'(cyc), 32'd6);
    chk("stall_hs", 32'(hs_cnt - hs0), 32'd6);
    chk("stall_queue", 32'(exp_q.size()), 32'd0);
    @(posedge sys_clk); #1;

    // Abort on the third address, with start raised in the same cycle.
    push_scan(1'b0, 1, 2, 0);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bus.addr_valid), 32'd0);
    chk("abort_last", 32'(bus.last), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'(AG_IDLE));
    chk("abort_popped", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    repeat (4) @(negedge sys_clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_stay_idle", 32'(busy), 32'd0);
    @(posedge sys_clk); #1;

    // Asynchronous reset in the middle of a scan, then a clean restart.
    push_scan(1'b0, 1, 2, 0);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(posedge sys_clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_addr", 32'(bus.address), 32'd0);
    chk("mrst_valid", 32'(bus.addr_valid), 32'd0);
    chk("mrst_last", 32'(bus.last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("mrst_idle_busy", 32'(busy), 32'd0);
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge sys_clk); #1;
    run_scan(1'b0, 1, 2, 0, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
